// File: rtl/fifo_mem.sv
// Word storage for stream_fifo: DEPTH x WIDTH array, one synchronous write port,
// one asynchronous read port. Contents are never reset.
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]           rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO, DEPTH words total; OUT_REG=0 is first-word-fall-through (latency 1),
// OUT_REG=1 adds an output register (latency 2). in_ready drops only on full or flush.
module stream_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2,
  parameter int OUT_REG    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;
  logic              st_empty, st_full, st_pop;
  logic [WIDTH-1:0]  mem_rdata;

  assign in_ready = (count_q < CW'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Pointers carry one extra lap bit: equal MSBs with equal address means empty.
  assign st_empty = (wr_ptr_q == rd_ptr_q);
  assign st_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push && !st_full),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  generate
    if (OUT_REG == 0) begin : g_fwft
      assign st_pop    = pop;
      assign out_valid = !st_empty;
      assign out_data  = mem_rdata;
    end else begin : g_oreg
      logic             ovld_q, ovld_d;
      logic [WIDTH-1:0] odat_q, odat_d;
      logic             load;

      // Refill whenever the register is empty or being drained this cycle.
      assign load   = !st_empty && (!ovld_q || pop);
      assign st_pop = load;

      always_comb begin
        ovld_d = ovld_q;
        odat_d = odat_q;
        if (load) begin
          ovld_d = 1'b1;
          odat_d = mem_rdata;
        end else if (pop) begin
          ovld_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst || flush) ovld_q <= 1'b0;
        else              ovld_q <= ovld_d;
        odat_q <= odat_d;
      end

      assign out_valid = ovld_q;
      assign out_data  = odat_q;
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, st_pop};
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // rst and flush both discard everything; either beats any push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count        = count_q;
  assign almost_full  = (count_q >= CW'(AFULL_LVL));
  assign almost_empty = (count_q <= CW'(AEMPTY_LVL));

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: OUT_REG=0 and OUT_REG=1 instances share stimulus, each
// checked against a queue model (word + push cycle) and a pop scoreboard.
module tb_stream_fifo;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic        irdy [2];
  logic        ovld [2];
  logic        af   [2];
  logic        ae   [2];
  logic [15:0] odat [2];
  logic [3:0]  cnt  [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [OUT_REG=%0d] actual=%0h required=%0h at cycle %0d", nm, k, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    stream_fifo #(
      .WIDTH      (16),
      .DEPTH      (8),
      .AFULL_LVL  (6),
      .AEMPTY_LVL (2),
      .OUT_REG    (g)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (irdy[g]),
      .in_data      (in_data),
      .out_valid    (ovld[g]),
      .out_ready    (out_ready),
      .out_data     (odat[g]),
      .count        (cnt[g]),
      .almost_full  (af[g]),
      .almost_empty (ae[g])
    );
  end

  // Reference: contents as a queue; head is visible once LAT cycles have passed since its push.
  for (genvar g = 0; g < 2; g++) begin : g_chk
    localparam int LAT = g + 1;
    logic [15:0] md [$];
    int          mt [$];
    logic [15:0] sb [$];

    function automatic bit pred_vld();
      return (md.size() > 0) && (cyc - mt[0] >= LAT);
    endfunction

    always @(posedge clk) begin : m_upd
      bit pv;
      bit pr;
      pv = pred_vld();
      pr = (md.size() < 8) && !flush;
      if (rst || flush) begin
        md.delete();
        mt.delete();
        sb.delete();
      end else begin
        if (pv && out_ready) begin
          void'(md.pop_front());
          void'(mt.pop_front());
        end
        if (in_valid && pr) begin
          md.push_back(in_data);
          mt.push_back(cyc);
          sb.push_back(in_data);
        end
      end
    end

    always @(negedge clk) begin
      if (armed) begin
        check("count",        g, int'(cnt[g]), md.size());
        check("in_ready",     g, int'(irdy[g]), int'((md.size() < 8) && !flush));
        check("out_valid",    g, int'(ovld[g]), int'(pred_vld()));
        check("almost_full",  g, int'(af[g]),   int'(md.size() >= 6));
        check("almost_empty", g, int'(ae[g]),   int'(md.size() <= 2));
        if (pred_vld() && ovld[g]) check("head_data", g, int'(odat[g]), int'(md[0]));
        if (ovld[g] && out_ready && !rst && !flush) begin
          if (sb.size() == 0) check("pop_with_empty_scoreboard", g, sb.size(), 1);
          else                check("pop_data", g, int'(odat[g]), int'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    int lat  [2];
    bit seen [2];
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step();
    armed = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_count",        k, int'(cnt[k]),  0);
      check("reset_out_valid",    k, int'(ovld[k]), 0);
      check("reset_in_ready",     k, int'(irdy[k]), 1);
      check("reset_almost_empty", k, int'(ae[k]),   1);
      check("reset_almost_full",  k, int'(af[k]),   0);
    end

    // Fill to capacity with the reader stalled
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("full_in_ready",    k, int'(irdy[k]), 0);
      check("full_count",       k, int'(cnt[k]),  8);
      check("full_almost_full", k, int'(af[k]),   1);
    end

    // Push offered while full and a pop happens: only the pop lands
    in_valid = 1'b1; in_data = 16'h0FFF; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("refused_push_count", k, int'(cnt[k]), 7);
    out_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("drained_count",        k, int'(cnt[k]), 0);
      check("drained_almost_empty", k, int'(ae[k]),  1);
    end

    // Latency from a single push into an empty FIFO
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hBEEF;
    step();
    in_valid = 1'b0;
    lat = '{0, 0};
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (ovld[k] && lat[k] == 0) lat[k] = c;
      step();
    end
    for (int k = 0; k < 2; k++) check("latency", k, lat[k], k + 1);
    out_ready = 1'b1;
    step();

    // Continuous stream across pointer wrap
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 16'h0100 + 16'(i);
      step();
      if (i == 10) begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("stream_count", k, int'(cnt[k]), k + 1);
      end
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Flush with a simultaneous push
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'h0200 + 16'(i);
      step();
    end
    in_valid = 1'b1; in_data = 16'hAAAA; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("flush_count",     k, int'(cnt[k]),  0);
      check("flush_out_valid", k, int'(ovld[k]), 0);
      check("flush_in_ready",  k, int'(irdy[k]), 1);
    end
    out_ready = 1'b1;
    repeat (3) step();

    // Reset mid-stream with a push in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'h0300 + 16'(i);
      step();
    end
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h0DEA;
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("midrst_count",        k, int'(cnt[k]),  0);
      check("midrst_out_valid",    k, int'(ovld[k]), 0);
      check("midrst_in_ready",     k, int'(irdy[k]), 1);
      check("midrst_almost_empty", k, int'(ae[k]),   1);
      check("midrst_almost_full",  k, int'(af[k]),   0);
    end
    in_valid = 1'b1; in_data = 16'h1234;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    seen = '{1'b0, 1'b0};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (ovld[k] && !seen[k]) begin
          seen[k] = 1'b1;
          check("first_after_reset", k, int'(odat[k]), 16'h1234);
        end
      end
      step();
    end
    for (int k = 0; k < 2; k++) check("first_after_reset_seen", k, int'(seen[k]), 1);

    // Random traffic: slow reader first, then fast reader
    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 79) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = (i < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) step();
    @(negedge clk);
    check("final_scoreboard_empty", 0, g_chk[0].sb.size(), 0);
    check("final_scoreboard_empty", 1, g_chk[1].sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
